// File: rtl/mostra_jogadas.sv
// mostra_jogadas
// Plays back a stored sequence of moves on the player LEDs. The moves come
// from an external synchronous 16x4 ROM. Each move is lit for T_ON cycles
// and is followed by T_OFF dark cycles. The moves shown are those at
// addresses 0 through limite.
//
// Ports
//   clock      system clock, all state changes on the rising edge
//   reset      synchronous, active-high reset
//   iniciar    start request, accepted only while idle (INICIAL)
//   limite     index of the last move to display (0..15)
//   dado       ROM read data, valid one cycle after endereco is presented
//   endereco   ROM address of the move being displayed
//   leds       move pattern (ROM data passed through while lit, else 0)
//   ocupado    high whenever the FSM is not in INICIAL
//   pronto     one-cycle pulse in FIM, after the last move has been shown
//   db_estado  FSM state code for debug displays:
//              0 INICIAL, 1 CARREGA, 2 MOSTRA, 3 APAGA, 4 PROXIMO, 5 FIM
module mostra_jogadas #(
  parameter int T_ON  = 1000,
  parameter int T_OFF = 500,
  parameter int N     = 12
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic [3:0] limite,
  input  logic [3:0] dado,
  output logic [3:0] endereco,
  output logic [3:0] leds,
  output logic       ocupado,
  output logic       pronto,
  output logic [3:0] db_estado
);

  typedef enum logic [3:0] {
    INICIAL = 4'd0,
    CARREGA = 4'd1,
    MOSTRA  = 4'd2,
    APAGA   = 4'd3,
    PROXIMO = 4'd4,
    FIM     = 4'd5
  } estado_t;

  // Terminal counts: the counter runs 0..T-1, so it leaves on value T-1.
  localparam logic [N-1:0] ULTIMO_ON  = N'(T_ON - 1);
  localparam logic [N-1:0] ULTIMO_OFF = N'(T_OFF - 1);
  localparam logic [N-1:0] UM         = N'(1);
  localparam logic [N-1:0] ZERO       = N'(0);

  estado_t        estado_r;
  logic [N-1:0]   contador_r;
  logic [3:0]     endereco_r;

  // State, interval counter and ROM address register.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado_r   <= INICIAL;
      contador_r <= ZERO;
      endereco_r <= 4'd0;
    end else begin
      case (estado_r)
        INICIAL: begin
          contador_r <= ZERO;
          endereco_r <= 4'd0;
          if (iniciar) begin
            estado_r <= CARREGA;
          end else begin
            estado_r <= INICIAL;
          end
        end
        // Address already stable; this cycle lets the ROM produce dado.
        CARREGA: begin
          contador_r <= ZERO;
          estado_r   <= MOSTRA;
        end
        MOSTRA: begin
          if (contador_r == ULTIMO_ON) begin
            contador_r <= ZERO;
            estado_r   <= APAGA;
          end else begin
            contador_r <= contador_r + UM;
            estado_r   <= MOSTRA;
          end
        end
        APAGA: begin
          if (contador_r == ULTIMO_OFF) begin
            contador_r <= ZERO;
            estado_r   <= PROXIMO;
          end else begin
            contador_r <= contador_r + UM;
            estado_r   <= APAGA;
          end
        end
        // Comparing before incrementing keeps endereco from ever passing
        // limite, so limite=15 finishes at 15 instead of wrapping to 0.
        PROXIMO: begin
          contador_r <= ZERO;
          if (endereco_r == limite) begin
            estado_r <= FIM;
          end else begin
            endereco_r <= endereco_r + 4'd1;
            estado_r   <= CARREGA;
          end
        end
        // Always passes through INICIAL, so a held iniciar restarts the
        // sequence from there on the cycle right after FIM.
        FIM: begin
          contador_r <= ZERO;
          endereco_r <= 4'd0;
          estado_r   <= INICIAL;
        end
        default: begin
          contador_r <= ZERO;
          endereco_r <= 4'd0;
          estado_r   <= INICIAL;
        end
      endcase
    end
  end

  // Output decode from the state register; leds passes dado through
  // unmodified while a move is lit.
  always_comb begin
    leds    = 4'b0000;
    ocupado = 1'b1;
    pronto  = 1'b0;
    if (estado_r == MOSTRA) begin
      leds = dado;
    end else begin
      leds = 4'b0000;
    end
    if (estado_r == INICIAL) begin
      ocupado = 1'b0;
    end else begin
      ocupado = 1'b1;
    end
    if (estado_r == FIM) begin
      pronto = 1'b1;
    end else begin
      pronto = 1'b0;
    end
  end

  assign endereco  = endereco_r;
  assign db_estado = estado_r;

endmodule

// File: tb/tb_mostra_jogadas.sv
// Self-checking bench for mostra_jogadas with T_ON=4, T_OFF=2.
// A timing model derives every output from the cycle offset since the
// first CARREGA cycle; directed runs add hand-computed expectations.
module tb_mostra_jogadas;

  localparam int T_ON  = 4;
  localparam int T_OFF = 2;
  localparam int P     = T_ON + T_OFF + 2;   // cycles per move

  localparam int S_INICIAL = 0;
  localparam int S_CARREGA = 1;
  localparam int S_MOSTRA  = 2;
  localparam int S_APAGA   = 3;
  localparam int S_PROXIMO = 4;
  localparam int S_FIM     = 5;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       iniciar = 1'b0;
  logic [3:0] limite = 4'd0;
  logic [3:0] dado = 4'd0;
  logic [3:0] endereco;
  logic [3:0] leds;
  logic       ocupado;
  logic       pronto;
  logic [3:0] db_estado;

  logic [3:0] rom [16] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                           4'd3, 4'd5, 4'd6, 4'd9, 4'd10, 4'd12, 4'd7,
                           4'd11, 4'd13, 4'd14, 4'd15, 4'd1};

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Model state
  bit m_busy = 1'b0;
  int m_k = 0;
  int m_lim = 0;

  // Observations from the directed runs
  int pron_n, busy_n, max_end;
  int led_cnt [16];

  mostra_jogadas #(.T_ON(T_ON), .T_OFF(T_OFF), .N(4)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .limite(limite),
    .dado(dado), .endereco(endereco), .leds(leds), .ocupado(ocupado),
    .pronto(pronto), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  // Synchronous ROM: data one cycle after the address.
  always @(posedge clock) dado <= rom[endereco];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: tracks whether a sequence runs and the cycle offset within it.
  always @(posedge clock) begin
    if (reset) begin
      m_busy <= 1'b0;
    end else if (!m_busy) begin
      if (iniciar) begin
        m_busy <= 1'b1;
        m_k    <= 0;
        m_lim  <= int'(limite);
      end
    end else if (m_k == (m_lim + 1) * P) begin
      m_busy <= 1'b0;
    end else begin
      m_k <= m_k + 1;
    end
  end

  // Compare process: every cycle, DUT outputs against the model.
  always @(negedge clock) begin
    if (chk_en) begin
      int e_st, e_end, e_leds, e_oc, e_pr, mv, ph;
      e_st = S_INICIAL; e_end = 0; e_leds = 0; e_oc = 0; e_pr = 0;
      if (m_busy) begin
        e_oc = 1;
        if (m_k == (m_lim + 1) * P) begin
          e_st = S_FIM; e_end = m_lim; e_pr = 1;
        end else begin
          mv = m_k / P;
          ph = m_k % P;
          e_end = mv;
          if (ph == 0) e_st = S_CARREGA;
          else if (ph <= T_ON) begin
            e_st = S_MOSTRA;
            e_leds = int'(rom[mv]);
          end
          else if (ph <= T_ON + T_OFF) e_st = S_APAGA;
          else e_st = S_PROXIMO;
        end
      end
      check("db_estado", int'(db_estado), e_st);
      check("endereco", int'(endereco), e_end);
      check("leds", int'(leds), e_leds);
      check("ocupado", int'(ocupado), e_oc);
      check("pronto", int'(pronto), e_pr);
    end
  end

  // Starts a sequence and watches it cycle by cycle (n=0 is CARREGA).
  // poke_n: cycle at which a one-cycle reset (poke_rst) or iniciar is driven.
  task automatic run_seq(input logic [3:0] lim, input int poke_n,
                         input bit poke_rst, input bit hold);
    bit done;
    done = 1'b0;
    limite = lim;
    @(negedge clock);
    iniciar = 1'b1;
    @(negedge clock);
    pron_n = -1; busy_n = 0; max_end = 0;
    for (int i = 0; i < 16; i++) led_cnt[i] = 0;
    for (int n = 0; n < 400; n++) begin
      if (!hold && n == 0) iniciar = 1'b0;
      if (n == poke_n) begin
        if (poke_rst) reset = 1'b1;
        else iniciar = 1'b1;
      end else if (n == poke_n + 1) begin
        reset = 1'b0;
        if (!hold) iniciar = 1'b0;
      end
      if (ocupado) busy_n++;
      if (pronto && pron_n < 0) pron_n = n;
      led_cnt[leds]++;
      if (int'(endereco) > max_end) max_end = int'(endereco);
      if (!ocupado) begin
        done = 1'b1;
        break;
      end
      @(negedge clock);
    end
    check("run_timeout", int'(done), 1);
  endtask

  initial begin
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    chk_en = 1'b1;
    check("rst_ocupado", int'(ocupado), 0);
    check("rst_leds", int'(leds), 0);
    check("rst_estado", int'(db_estado), S_INICIAL);

    // Three moves, single-cycle start pulse.
    run_seq(4'd2, -10, 1'b0, 1'b0);
    check("l2_pronto_at", pron_n, 24);
    check("l2_busy", busy_n, 25);
    check("l2_led1", led_cnt[1], 4);
    check("l2_led2", led_cnt[2], 4);
    check("l2_led4", led_cnt[4], 4);
    check("l2_max_end", max_end, 2);

    // Single move.
    run_seq(4'd0, -10, 1'b0, 1'b0);
    check("l0_pronto_at", pron_n, 8);
    check("l0_busy", busy_n, 9);
    check("l0_max_end", max_end, 0);

    // All sixteen moves.
    run_seq(4'd15, -10, 1'b0, 1'b0);
    check("l15_pronto_at", pron_n, 128);
    check("l15_max_end", max_end, 15);
    check("l15_led1", led_cnt[1], 8);

    // iniciar again during MOSTRA of move 1 changes nothing.
    run_seq(4'd2, 10, 1'b0, 1'b0);
    check("ini_pronto_at", pron_n, 24);
    check("ini_busy", busy_n, 25);

    // reset during APAGA of move 1 aborts with no pronto.
    run_seq(4'd2, 13, 1'b1, 1'b0);
    check("rst_no_pronto", pron_n, -1);
    check("rst_busy", busy_n, 14);
    check("rst_end", int'(endereco), 0);
    run_seq(4'd2, -10, 1'b0, 1'b0);
    check("replay_pronto_at", pron_n, 24);
    check("replay_led1", led_cnt[1], 4);

    // iniciar held high: FIM, INICIAL, then a new CARREGA.
    run_seq(4'd0, -10, 1'b0, 1'b1);
    check("hold_pronto_at", pron_n, 8);
    check("hold_after_fim", int'(db_estado), S_INICIAL);
    @(negedge clock);
    check("hold_restart", int'(db_estado), S_CARREGA);
    iniciar = 1'b0;
    for (int n = 0; n < 50 && ocupado; n++) @(negedge clock);
    check("hold_second_done", int'(ocupado), 0);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
